// File: rtl/sm4_rkey_store.sv
// rtl/sm4_rkey_store.sv - SM4 round-key store: loads ROUNDS keys in order, replays them ascending or descending
module sm4_rkey_store #(
    parameter int WORD_WIDTH = 32,
    parameter int ROUNDS     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  key_load,
    input  logic                  rk_wr_en,
    input  logic [WORD_WIDTH-1:0] rk_wr_data,
    input  logic                  rd_start,
    input  logic                  rd_mode,
    output logic                  keys_ready,
    output logic                  rd_valid,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [4:0]            rd_round,
    output logic                  rd_last
);

    localparam int IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(ROUNDS - 1);
    localparam logic [4:0]    LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOADING,
        S_READY,
        S_READING
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]         rd_idx_q, rd_idx_d;
    logic                  rd_mode_q, rd_mode_d;
    logic                  keys_ready_q, keys_ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [4:0]            rd_round_q, rd_round_d;
    logic                  rd_last_q, rd_last_d;
    logic                  mem_we;

    // Key storage is deliberately not reset; the state machine alone gates reads.
    logic [WORD_WIDTH-1:0] mem [ROUNDS];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= rk_wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_idx_d   = rd_idx_q;
        rd_mode_d  = rd_mode_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_round_d = rd_round_q;
        rd_last_d  = rd_last_q;
        mem_we     = 1'b0;

        if (key_load) begin
            state_d    = S_LOADING;
            wr_ptr_d   = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_LOADING: begin
                    if (rk_wr_en) begin
                        mem_we = 1'b1;
                        if (wr_ptr_q == LAST_IDX) begin
                            wr_ptr_d = '0;
                            state_d  = S_READY;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (rd_start && !stall) begin
                        state_d    = S_READING;
                        rd_mode_d  = rd_mode;
                        rd_idx_d   = rd_mode ? LAST_IDX : '0;
                        rd_data_d  = mem[rd_idx_d];
                        rd_valid_d = 1'b1;
                        rd_round_d = '0;
                        rd_last_d  = (LAST_ROUND == 5'd0);
                    end
                end
                S_READING: begin
                    // Termination follows the beat count, so the index never wraps.
                    if (!stall) begin
                        if (rd_last_q) begin
                            state_d    = S_READY;
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            rd_data_d  = '0;
                        end else begin
                            rd_idx_d   = rd_mode_q ? rd_idx_q - 1'b1 : rd_idx_q + 1'b1;
                            rd_data_d  = mem[rd_idx_d];
                            rd_round_d = rd_round_q + 5'd1;
                            rd_last_d  = (rd_round_d == LAST_ROUND);
                        end
                    end
                end
                default: ;
            endcase
        end

        keys_ready_d = (state_d == S_READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            wr_ptr_q     <= '0;
            rd_idx_q     <= '0;
            rd_mode_q    <= 1'b0;
            keys_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_round_q   <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_idx_q     <= rd_idx_d;
            rd_mode_q    <= rd_mode_d;
            keys_ready_q <= keys_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_round_q   <= rd_round_d;
            rd_last_q    <= rd_last_d;
        end
    end

    assign keys_ready = keys_ready_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_round   = rd_round_q;
    assign rd_last    = rd_last_q;

endmodule

// File: tb/tb_sm4_rkey_store.sv
// tb/tb_sm4_rkey_store.sv - directed self-checking bench for sm4_rkey_store
module tb_sm4_rkey_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        key_load;
    logic        rk_wr_en;
    logic [31:0] rk_wr_data;
    logic        rd_start;
    logic        rd_mode;
    logic        keys_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [4:0]  rd_round;
    logic        rd_last;

    int checks = 0;
    int errors = 0;

    sm4_rkey_store #(.WORD_WIDTH(32), .ROUNDS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .key_load   (key_load),
        .rk_wr_en   (rk_wr_en),
        .rk_wr_data (rk_wr_data),
        .rd_start   (rd_start),
        .rd_mode    (rd_mode),
        .keys_ready (keys_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_round   (rd_round),
        .rd_last    (rd_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_key_load();
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic write_keys(input logic [31:0] base, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            rk_wr_en   = 1'b1;
            rk_wr_data = base + 32'(i);
            @(negedge clk);
        end
        rk_wr_en = 1'b0;
    endtask

    task automatic try_start(input string tag);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        chk(tag, rd_valid, 1'b0);
    endtask

    // Negative beat numbers disable stall / key_load abort / async reset injection.
    task automatic read_seq(input logic mode, input logic [31:0] base,
                            input int stall_at, input int abort_at, input int rst_at);
        logic [31:0] exp;
        rd_start = 1'b1;
        rd_mode  = mode;
        @(negedge clk);
        rd_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            exp = base + 32'(mode ? 31 - b : b);
            chk("beat_valid", rd_valid, 1'b1);
            chk("beat_data", rd_data, exp);
            chk("beat_round", rd_round, b);
            chk("beat_last", rd_last, b == 31);
            chk("beat_keys_ready", keys_ready, 1'b0);
            if (b == abort_at) begin
                key_load = 1'b1;
                @(negedge clk);
                key_load = 1'b0;
                chk("abort_valid", rd_valid, 1'b0);
                chk("abort_keys_ready", keys_ready, 1'b0);
                return;
            end
            if (b == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("arst_keys_ready", keys_ready, 1'b0);
                chk("arst_valid", rd_valid, 1'b0);
                chk("arst_data", rd_data, 32'h0);
                chk("arst_round", rd_round, 5'd0);
                chk("arst_last", rd_last, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (b == stall_at) begin
                stall = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_valid", rd_valid, 1'b1);
                    chk("stall_data", rd_data, exp);
                    chk("stall_round", rd_round, b);
                end
                stall = 1'b0;
            end
            if (b == 31) rd_start = 1'b1;
            @(negedge clk);
            rd_start = 1'b0;
        end
        chk("end_valid", rd_valid, 1'b0);
        chk("end_last", rd_last, 1'b0);
        chk("end_keys_ready", keys_ready, 1'b1);
        @(negedge clk);
        chk("end_not_queued", rd_valid, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        key_load   = 1'b0;
        rk_wr_en   = 1'b0;
        rk_wr_data = 32'h0;
        rd_start   = 1'b0;
        rd_mode    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_keys_ready", keys_ready, 1'b0);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, 32'h0);
        chk("rst_round", rd_round, 5'd0);
        chk("rst_last", rd_last, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        try_start("empty_start_ignored");

        pulse_key_load();
        write_keys(32'hA000_0000, 0, 32);
        chk("load_keys_ready", keys_ready, 1'b1);
        read_seq(1'b0, 32'hA000_0000, -1, -1, -1);
        read_seq(1'b1, 32'hA000_0000, -1, -1, -1);

        stall    = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        stall    = 1'b0;
        chk("stalled_start_valid", rd_valid, 1'b0);
        @(negedge clk);
        chk("stalled_start_not_queued", rd_valid, 1'b0);
        chk("stalled_start_keys_ready", keys_ready, 1'b1);

        read_seq(1'b0, 32'hA000_0000, 5, -1, -1);

        read_seq(1'b0, 32'hA000_0000, -1, 10, -1);
        try_start("reload_start_ignored_a");
        write_keys(32'hB000_0000, 0, 16);
        chk("half_load_keys_ready", keys_ready, 1'b0);
        try_start("reload_start_ignored_b");
        stall = 1'b1;
        write_keys(32'hB000_0000, 16, 16);
        stall = 1'b0;
        chk("stalled_load_keys_ready", keys_ready, 1'b1);
        read_seq(1'b0, 32'hB000_0000, -1, -1, -1);

        pulse_key_load();
        write_keys(32'hC000_0000, 0, 31);
        chk("31_keys_ready", keys_ready, 1'b0);
        try_start("31_keys_start_ignored");
        write_keys(32'hC000_0000, 31, 1);
        chk("32_keys_ready", keys_ready, 1'b1);
        write_keys(32'hDEAD_BEEF, 0, 1);
        chk("33rd_keys_ready", keys_ready, 1'b1);
        read_seq(1'b1, 32'hC000_0000, -1, -1, -1);

        read_seq(1'b1, 32'hC000_0000, -1, -1, 7);
        chk("post_rst_keys_ready", keys_ready, 1'b0);
        try_start("post_rst_start_ignored");
        pulse_key_load();
        write_keys(32'hD000_0000, 0, 32);
        read_seq(1'b1, 32'hD000_0000, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
